// File: rtl/mux_nx1_scan.sv
// N-channel WIDTH-bit registered mux with direct-load and round-robin scan selection.
// Optional macro MUX_SCAN_MASK_EN adds a ch_mask input that restricts which channels are scanned.
module mux_nx1_scan #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH*WIDTH-1:0]   din,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]         ch_mask,
`endif
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    output logic [SEL_W-1:0]        cur_ch,
    output logic                    wrap,
    output logic                    sel_err,
    output logic                    state_dbg
);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    localparam logic [SEL_W:0]   N_CH_W   = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [7:0]       DWELL_M1 = 8'(DWELL - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               wrap_q, wrap_d;
    logic               sel_err_q, sel_err_d;

    logic [WIDTH-1:0]   ch_data;
    logic [SEL_W-1:0]   nxt_ch;
    logic               nxt_wrap;
    logic               scan_none;
    logic               sel_ok;

    assign sel_ok = ({1'b0, sel} < N_CH_W);

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch_q == SEL_W'(k)) begin
                ch_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_SCAN_MASK_EN
    logic [SEL_W-1:0] hi_ch, lo_ch;
    logic             found_hi;

    // Descending walk: the last hit is the lowest enabled index, both above cur_ch and overall.
    always_comb begin
        hi_ch    = '0;
        lo_ch    = '0;
        found_hi = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                if (SEL_W'(k) > cur_ch_q) begin
                    hi_ch    = SEL_W'(k);
                    found_hi = 1'b1;
                end
                lo_ch = SEL_W'(k);
            end
        end
    end

    assign scan_none = (ch_mask == '0);
    assign nxt_ch    = found_hi ? hi_ch : lo_ch;
    assign nxt_wrap  = !found_hi && !scan_none;
`else
    assign scan_none = 1'b0;
    assign nxt_ch    = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + SEL_W'(1);
    assign nxt_wrap  = (cur_ch_q == LAST_CH);
`endif

    // mode is applied on the same edge it is sampled, so DIRECT actions use the incoming mode.
    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        wrap_d       = 1'b0;
        sel_err_d    = sel_err_q;
        if (en) begin
            state_d      = mode ? ST_SCAN : ST_DIRECT;
            dout_d       = ch_data;
            dout_valid_d = 1'b1;
            if (state_d == ST_DIRECT) begin
                cnt_d = '0;
                if (load) begin
                    if (sel_ok) begin
                        cur_ch_d = sel;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end else begin
                if (scan_none) begin
                    dout_valid_d = 1'b0;
                end
                if (cnt_q == DWELL_M1) begin
                    cnt_d = '0;
                    if (!scan_none) begin
                        cur_ch_d = nxt_ch;
                        wrap_d   = nxt_wrap;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DIRECT;
            cur_ch_q     <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_ch_q     <= cur_ch_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wrap_q       <= wrap_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cur_ch     = cur_ch_q;
    assign wrap       = wrap_q;
    assign sel_err    = sel_err_q;
    assign state_dbg  = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: non-power-of-two channel count, random data, reference model with scoreboard.
// Handshake: one expected state entry per driven cycle; a dout entry only when dout_valid is expected high.
module tb_mux_nx1_scan;

    localparam int N_CH  = 6;
    localparam int WIDTH = 4;
    localparam int SEL_W = 3;
    localparam int DWELL = 3;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] cur;
        logic             wrp;
        logic             err;
        logic             st;
    } st_t;

    logic                  clk, rst_n, en, mode, load;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] din;
`ifdef MUX_SCAN_MASK_EN
    logic [N_CH-1:0]       ch_mask;
`endif
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid, wrap, sel_err, state_dbg;
    logic [SEL_W-1:0]      cur_ch;

    logic [WIDTH-1:0] exp_q[$];
    st_t              st_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               m_cur, m_cnt;
    bit               m_err, m_st;

    mux_nx1_scan #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL(DWELL)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel), .din(din),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask),
`endif
        .dout(dout), .dout_valid(dout_valid), .cur_ch(cur_ch), .wrap(wrap),
        .sel_err(sel_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_err = 1'b0; m_st = 1'b0;
        exp_q.delete();
        st_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"},      32'(dout),       32'd0);
        chk({tag, "_valid"},     32'(dout_valid), 32'd0);
        chk({tag, "_cur_ch"},    32'(cur_ch),     32'd0);
        chk({tag, "_wrap"},      32'(wrap),       32'd0);
        chk({tag, "_sel_err"},   32'(sel_err),    32'd0);
        chk({tag, "_state"},     32'(state_dbg),  32'd0);
    endtask

    // driver: one call = one clock cycle of stimulus plus the expected result of that edge
    task automatic step(input bit e, input bit m, input bit l, input int s);
        logic [N_CH-1:0]  mk;
        logic [WIDTH-1:0] data;
        bit               valid, wr;
        st_t              x;
        @(negedge clk);
        en = e; mode = m; load = l; sel = SEL_W'(s);
        din = {$urandom, $urandom};
`ifdef MUX_SCAN_MASK_EN
        mk = ch_mask;
`else
        mk = '1;
`endif
        valid = 1'b0;
        wr    = 1'b0;
        if (e) begin
            data  = din[m_cur*WIDTH +: WIDTH];
            valid = 1'b1;
            m_st  = m;
            if (!m) begin
                m_cnt = 0;
                if (l) begin
                    if (s < N_CH) m_cur = s;
                    else          m_err = 1'b1;
                end
            end else begin
                if (mk == '0) valid = 1'b0;
                if (m_cnt == DWELL - 1) begin
                    m_cnt = 0;
                    if (mk != '0) begin
                        for (int off = 1; off <= N_CH; off++) begin
                            int c;
                            c = (m_cur + off) % N_CH;
                            if (mk[c]) begin
                                wr    = (c <= m_cur);
                                m_cur = c;
                                break;
                            end
                        end
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (valid) exp_q.push_back(data);
        end
        x.valid = valid;
        x.cur   = SEL_W'(m_cur);
        x.wrp   = wr;
        x.err   = m_err;
        x.st    = m_st;
        st_q.push_back(x);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (st_q.size() > 0) begin
                    st_t x;
                    x = st_q.pop_front();
                    chk("dout_valid", 32'(dout_valid), 32'(x.valid));
                    chk("cur_ch",     32'(cur_ch),     32'(x.cur));
                    chk("wrap",       32'(wrap),       32'(x.wrp));
                    chk("sel_err",    32'(sel_err),    32'(x.err));
                    chk("state",      32'(state_dbg),  32'(x.st));
                end
                if (dout_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dout_unexpected: got valid dout %0h with nothing expected at %0t", dout, $time);
                    end else begin
                        chk("dout", 32'(dout), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        bit cur_mode;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0;
        din = {$urandom, $urandom};
`ifdef MUX_SCAN_MASK_EN
        ch_mask = '1;
`endif
        model_reset();
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // direct sweep over every legal channel
        for (int s = 0; s < N_CH; s++) begin
            step(1, 0, 1, s);
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
        end

        // out-of-range loads set the sticky error and leave the channel alone
        step(1, 0, 1, 7);
        step(1, 0, 1, 6);
        step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);

        // two full scan laps starting from channel 0; load/sel must be ignored
        step(1, 0, 1, 0);
        for (int i = 0; i < 2 * N_CH * DWELL + 2; i++)
            step(1, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7));

        // en gating mid-dwell
        step(1, 0, 1, 3);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // leave scan at channel 5 with a same-edge load of 2
        for (int i = 0; i < 40 && !(m_cur == 5 && m_cnt == 1); i++) step(1, 1, 0, 0);
        step(1, 0, 1, 2);
        step(1, 0, 0, 0);

`ifdef MUX_SCAN_MASK_EN
        ch_mask = 6'b10_0100;
        step(1, 0, 1, 0);
        for (int i = 0; i < 4 * DWELL * 3; i++) step(1, 1, 0, 0);
        ch_mask = '0;
        for (int i = 0; i < 2 * DWELL; i++) step(1, 1, 0, 0);
        ch_mask = '1;
`endif

        // random mix
        cur_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
`ifdef MUX_SCAN_MASK_EN
            if ($urandom_range(0, 31) == 0) ch_mask = N_CH'($urandom);
`endif
            step(1'($urandom_range(0, 7) != 0), cur_mode, 1'($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7));
        end

        // reset in the middle of a scan, then confirm DIRECT afterwards
        step(1, 0, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 4);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("st_q_drained",  32'(st_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
